// File: rtl/edge_event_counter.sv
// Counts synchronized rising edges of an asynchronous level input, with
// terminal-count pulse, sticky overflow and wrap/saturate selection.
module edge_event_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter bit WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             edge_pulse,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             at_last;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             ovf_next;

  // s1/s2 resolve metastability on din; s3 is the history used for edge detect.
  // rst is expected to be released synchronously by the surrounding logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign at_last = (count == LAST);

  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    ovf_next   = ovf;
    if (clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (rise && en) begin
      if (at_last) begin
        // With MODULUS == 2^WIDTH this is the natural binary rollover point.
        tc_next    = 1'b1;
        ovf_next   = 1'b1;
        count_next = WRAP ? '0 : LAST;
      end else begin
        count_next = count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      edge_pulse <= 1'b0;
      tc         <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      count      <= count_next;
      edge_pulse <= rise;
      tc         <= tc_next;
      ovf        <= ovf_next;
    end
  end

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench for edge_event_counter: one wrapping and one saturating
// instance share all inputs and are checked against hand-computed vectors.
module tb_edge_event_counter;

  logic       clk;
  logic       rst;
  logic       din;
  logic       en;
  logic       clr;
  logic [3:0] cnt_w;
  logic       ep_w;
  logic       tc_w;
  logic       ovf_w;
  logic [3:0] cnt_s;
  logic       ep_s;
  logic       tc_s;
  logic       ovf_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] cw;
    logic       tcw;
    logic       ovw;
    logic [3:0] cs;
    logic       tcs;
    logic       ovs;
  } vec_t;

  vec_t vecs[22];

  edge_event_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
    .count(cnt_w), .edge_pulse(ep_w), .tc(tc_w), .ovf(ovf_w)
  );

  edge_event_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
    .count(cnt_s), .edge_pulse(ep_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic e, input logic c,
                              input logic [3:0] cw, input logic tcw, input logic ovw,
                              input logic [3:0] cs, input logic tcs, input logic ovs);
    vec_t v;
    v.en = e; v.clr = c;
    v.cw = cw; v.tcw = tcw; v.ovw = ovw;
    v.cs = cs; v.tcs = tcs; v.ovs = ovs;
    return v;
  endfunction

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk4({tag, "_cnt_w"}, cnt_w, 4'd0);
    chk1({tag, "_ep_w"}, ep_w, 1'b0);
    chk1({tag, "_tc_w"}, tc_w, 1'b0);
    chk1({tag, "_ovf_w"}, ovf_w, 1'b0);
    chk4({tag, "_cnt_s"}, cnt_s, 4'd0);
    chk1({tag, "_ep_s"}, ep_s, 1'b0);
    chk1({tag, "_tc_s"}, tc_s, 1'b0);
    chk1({tag, "_ovf_s"}, ovf_s, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // din rises before edge k and is held through k+2, where the count updates;
  // en/clr are presented for edge k+2 only.
  task automatic do_rise(input vec_t v, input string tag);
    din = 1'b1;
    en  = v.en;
    clr = 1'b0;
    step();
    step();
    clr = v.clr;
    step();
    chk1({tag, "_ep_w"}, ep_w, 1'b1);
    chk1({tag, "_ep_s"}, ep_s, 1'b1);
    chk4({tag, "_cnt_w"}, cnt_w, v.cw);
    chk1({tag, "_tc_w"}, tc_w, v.tcw);
    chk1({tag, "_ovf_w"}, ovf_w, v.ovw);
    chk4({tag, "_cnt_s"}, cnt_s, v.cs);
    chk1({tag, "_tc_s"}, tc_s, v.tcs);
    chk1({tag, "_ovf_s"}, ovf_s, v.ovs);
    clr = 1'b0;
    din = 1'b0;
    step();
    chk1({tag, "_ep_off_w"}, ep_w, 1'b0);
    chk1({tag, "_ep_off_s"}, ep_s, 1'b0);
    chk1({tag, "_tc_off_w"}, tc_w, 1'b0);
    chk1({tag, "_tc_off_s"}, tc_s, 1'b0);
    chk4({tag, "_hold_w"}, cnt_w, v.cw);
    chk4({tag, "_hold_s"}, cnt_s, v.cs);
    chk1({tag, "_ovf_hold_w"}, ovf_w, v.ovw);
    chk1({tag, "_ovf_hold_s"}, ovf_s, v.ovs);
    step();
    step();
  endtask

  initial begin
    int idx;
    idx = 0;
    for (int i = 1; i <= 9; i++) begin
      vecs[idx] = mk(1'b1, 1'b0, 4'(i), 1'b0, 1'b0, 4'(i), 1'b0, 1'b0);
      idx++;
    end
    vecs[idx] = mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1); idx++;
    vecs[idx] = mk(1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1); idx++;
    vecs[idx] = mk(1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1); idx++;
    for (int i = 0; i < 3; i++) begin
      vecs[idx] = mk(1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
      idx++;
    end
    for (int i = 3; i <= 7; i++) begin
      vecs[idx] = mk(1'b1, 1'b0, 4'(i), 1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
      idx++;
    end
    vecs[idx] = mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); idx++;
    vecs[idx] = mk(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);

    // Reset held while din toggles every 7 ns: everything stays at zero.
    rst = 1'b1;
    din = 1'b0;
    en  = 1'b1;
    clr = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (t % 7 == 6) din = ~din;
      chk_zero("rst_hold");
    end

    // din high through reset release: one pulse at the third edge, only once.
    din = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk1($sformatf("rel_ep_w_e%0d", e), ep_w, (e == 3));
      chk1($sformatf("rel_ep_s_e%0d", e), ep_s, (e == 3));
      chk4($sformatf("rel_cnt_w_e%0d", e), cnt_w, (e >= 3) ? 4'd1 : 4'd0);
      chk4($sformatf("rel_cnt_s_e%0d", e), cnt_s, (e >= 3) ? 4'd1 : 4'd0);
    end
    din = 1'b0;
    step();
    step();
    step();

    // Asynchronous reset clears the count without a clock edge.
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) do_rise(vecs[i], $sformatf("vec%0d", i));

    for (int i = 2; i <= 5; i++)
      do_rise(mk(1'b1, 1'b0, 4'(i), 1'b0, 1'b0, 4'(i), 1'b0, 1'b0), $sformatf("post%0d", i));

    // count=5, reset 2 ns after an edge clears outputs before the next edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("mid_rst_a");
    #5;
    chk_zero("mid_rst_b");
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_counter.md
EDGE_EVENT_COUNTER -- requirements
Module: edge_event_counter

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, 4, counter width in bits.
REQ-003 Parameter MODULUS, 10, count range 0..MODULUS-1; legal values are 2..2^WIDTH.
REQ-004 Parameter WRAP, 1: 1 = wrap to 0 at terminal count; 0 = saturate at MODULUS-1.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 din  input  1  event level input, driven by an upstream flip-flop q; asynchronous to clk.
REQ-008 en  input  1  count enable, synchronous.
REQ-009 clr  input  1  synchronous clear of count, tc and ovf.
REQ-010 count  output  WIDTH  current event count.
REQ-011 edge_pulse  output  1  registered one-cycle pulse per detected din rising edge.
REQ-012 tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 ovf  output  1  sticky overflow flag.

Function
REQ-014 din SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3; rise = s2 AND NOT s3.
REQ-015 Latency: din high at clk edge k (setup met) -> s1=1 after k, s2=1 after k+1, edge_pulse=1 and count updated after edge k+2; edge_pulse SHALL stay high exactly one cycle per rise.
REQ-016 A din high pulse shorter than one clk period MAY be missed; a din level held at least two clk periods SHALL be detected exactly once.
REQ-017 edge_pulse SHALL follow rise regardless of en and clr.
REQ-018 Priority at each edge: clr > (rise AND en) > hold.
REQ-019 clr=1: count=0, tc=0, ovf=0 at the next edge, even if rise is coincident.
REQ-020 rise AND en with count < MODULUS-1: count = count+1, tc=0.
REQ-021 rise AND en with count == MODULUS-1, WRAP=1: count=0, tc=1 for one cycle, ovf=1.
REQ-022 rise AND en with count == MODULUS-1, WRAP=0: count holds MODULUS-1, tc=1 for one cycle, ovf=1; this repeats on each later rise.
REQ-023 en=0 or no rise: count holds and tc=0 in the following cycle.
REQ-024 Once set, ovf SHALL remain 1 until clr or rst.
REQ-025 count SHALL never take a value >= MODULUS.
REQ-026 When MODULUS = 2^WIDTH, the natural binary rollover SHALL match REQ-021 and REQ-022.

Reset
REQ-027 On assertion, rst SHALL immediately clear s1, s2, s3, count, edge_pulse, tc and ovf to 0, without waiting for a clock edge.
REQ-028 While rst=1, all outputs SHALL remain 0 regardless of din, en and clr.
REQ-029 If din is held high through reset release, the block SHALL detect one rise and assert edge_pulse at the third clk edge after release.
REQ-030 Reset deassertion SHALL occur synchronous to clk; the block SHALL NOT include an internal reset synchronizer.

Verification (WIDTH=4, MODULUS=10, clk period 10 ns)
REQ-031 rst=1, din toggling every 7 ns for 50 ns -> count=0, edge_pulse=0, tc=0, ovf=0 throughout.
REQ-032 en=1, din 0->1 3 ns before edge k and held -> edge_pulse=1 only in the cycle after edge k+2, count=1.
REQ-033 WRAP=1, en=1, 10 isolated rises -> count steps 1..9 then 0; tc=1 for one cycle on the 10th rise; ovf=1; 11th rise -> count=1, ovf still 1.
REQ-034 WRAP=0, en=1, 12 rises -> count saturates at 9; tc pulses on rises 10, 11 and 12; ovf=1.
REQ-035 en=0 with 3 rises -> 3 edge_pulse pulses and count unchanged; then clr=1 coincident with a rise while en=1 and count=7, ovf=1 -> count=0, ovf=0, tc=0, edge_pulse=1.
REQ-036 count=5, rst asserted 2 ns after a clk edge -> count, edge_pulse, tc and ovf read 0 before the next clk edge.
